// File: rtl/alu_operand_issue.sv
// Execute-stage operand issue register: captures decoded instructions, forwards from EX/MEM and MEM/WB, and stalls on load-use.
// Optional stall-cycle counter output enabled by defining ALU_ISSUE_STALL_CNT_EN.
module alu_operand_issue #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rs_idx,
  input  logic [RW-1:0] in_rt_idx,
  input  logic [DW-1:0] in_rs_val,
  input  logic [DW-1:0] in_rt_val,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,
  input  logic [CW-1:0] in_cmd,
  input  logic [RW-1:0] in_rd_idx,
  input  logic          flush,
  input  logic          ex_fwd_valid,
  input  logic [RW-1:0] ex_fwd_idx,
  input  logic [DW-1:0] ex_fwd_data,
  input  logic          ex_fwd_is_load,
  input  logic          wb_fwd_valid,
  input  logic [RW-1:0] wb_fwd_idx,
  input  logic [DW-1:0] wb_fwd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] opa,
  output logic [DW-1:0] opb,
  output logic [CW-1:0] cmd,
  output logic [RW-1:0] out_rd_idx
`ifdef ALU_ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, FULL, STALL} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] rs_idx_q, rs_idx_d, rt_idx_q, rt_idx_d, rd_q, rd_d;
  logic [DW-1:0] rs_val_q, rs_val_d, rt_val_q, rt_val_d, imm_q, imm_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
  logic          use_imm_q, use_imm_d;
  logic [CW-1:0] cmd_q, cmd_d;
  logic          haz_in, haz_held, capture;

  // Register zero reads as 0; non-load EX result beats WB, WB beats the fallback value.
  function automatic logic [DW-1:0] resolve_op(input logic [RW-1:0] idx,
                                               input logic [DW-1:0] fallback,
                                               input logic use_ex);
    if (idx == '0)
      return '0;
    if (use_ex && ex_fwd_valid && !ex_fwd_is_load && ex_fwd_idx == idx)
      return ex_fwd_data;
    if (wb_fwd_valid && wb_fwd_idx == idx)
      return wb_fwd_data;
    return fallback;
  endfunction

  function automatic logic load_hazard(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                       input logic uimm);
    return ex_fwd_valid && ex_fwd_is_load && ex_fwd_idx != '0 &&
           (ex_fwd_idx == rs || (ex_fwd_idx == rt && !uimm));
  endfunction

  assign haz_in   = load_hazard(in_rs_idx, in_rt_idx, in_use_imm);
  assign haz_held = load_hazard(rs_idx_q, rt_idx_q, use_imm_q);

  always_comb begin
    state_d   = state_q;
    rs_idx_d  = rs_idx_q;
    rt_idx_d  = rt_idx_q;
    rs_val_d  = rs_val_q;
    rt_val_d  = rt_val_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    cmd_d     = cmd_q;
    rd_d      = rd_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    in_ready  = 1'b0;
    capture   = 1'b0;

    case (state_q)
      EMPTY: begin
        in_ready = !flush;
        capture  = in_valid && !flush;
      end
      FULL: begin
        in_ready = out_ready && !flush;
        if (flush) begin
          state_d = EMPTY;
        end else if (out_ready) begin
          capture = in_valid;
          if (!in_valid)
            state_d = EMPTY;
        end else begin
          // Held operands only track a retiring WB producer; EX data may not be valid yet.
          opa_d = resolve_op(rs_idx_q, opa_q, 1'b0);
          if (!use_imm_q)
            opb_d = resolve_op(rt_idx_q, opb_q, 1'b0);
        end
      end
      STALL: begin
        if (flush) begin
          state_d = EMPTY;
        end else if (!haz_held) begin
          opa_d   = resolve_op(rs_idx_q, rs_val_q, 1'b1);
          opb_d   = use_imm_q ? imm_q : resolve_op(rt_idx_q, rt_val_q, 1'b1);
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (capture) begin
      rs_idx_d  = in_rs_idx;
      rt_idx_d  = in_rt_idx;
      rs_val_d  = in_rs_val;
      rt_val_d  = in_rt_val;
      imm_d     = in_imm;
      use_imm_d = in_use_imm;
      cmd_d     = in_cmd;
      rd_d      = in_rd_idx;
      if (haz_in) begin
        state_d = STALL;
      end else begin
        opa_d   = resolve_op(in_rs_idx, in_rs_val, 1'b1);
        opb_d   = in_use_imm ? in_imm : resolve_op(in_rt_idx, in_rt_val, 1'b1);
        state_d = FULL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      rs_idx_q  <= '0;
      rt_idx_q  <= '0;
      rs_val_q  <= '0;
      rt_val_q  <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      cmd_q     <= '0;
      rd_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
    end else begin
      state_q   <= state_d;
      rs_idx_q  <= rs_idx_d;
      rt_idx_q  <= rt_idx_d;
      rs_val_q  <= rs_val_d;
      rt_val_q  <= rt_val_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
      cmd_q     <= cmd_d;
      rd_q      <= rd_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign opa        = opa_q;
  assign opb        = opb_q;
  assign cmd        = cmd_q;
  assign out_rd_idx = rd_q;

`ifdef ALU_ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (state_q == STALL && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed scoreboard bench for alu_operand_issue: expected ALU issues are queued at drive time
// and popped whenever the DUT transfers (out_valid & out_ready) on the falling edge.
module tb_alu_operand_issue;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [RW-1:0] in_rs_idx, in_rt_idx, in_rd_idx;
  logic [DW-1:0] in_rs_val, in_rt_val, in_imm;
  logic          in_use_imm;
  logic [CW-1:0] in_cmd;
  logic          flush;
  logic          ex_fwd_valid, ex_fwd_is_load;
  logic [RW-1:0] ex_fwd_idx;
  logic [DW-1:0] ex_fwd_data;
  logic          wb_fwd_valid;
  logic [RW-1:0] wb_fwd_idx;
  logic [DW-1:0] wb_fwd_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] opa, opb;
  logic [CW-1:0] cmd;
  logic [RW-1:0] out_rd_idx;
`ifdef ALU_ISSUE_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  typedef struct {
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [CW-1:0] cmd;
    logic [RW-1:0] rd;
  } issue_t;

  issue_t expQ[$];
  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  always #5 clk = ~clk;

  alu_operand_issue #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_cmd(in_cmd), .in_rd_idx(in_rd_idx),
    .flush(flush),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_idx(ex_fwd_idx),
    .ex_fwd_data(ex_fwd_data), .ex_fwd_is_load(ex_fwd_is_load),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_idx(wb_fwd_idx), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .opa(opa), .opb(opb), .cmd(cmd), .out_rd_idx(out_rd_idx)
`ifdef ALU_ISSUE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    in_valid = 0; in_rs_idx = 0; in_rt_idx = 0; in_rs_val = 0; in_rt_val = 0;
    in_imm = 0; in_use_imm = 0; in_cmd = 0; in_rd_idx = 0; flush = 0;
    ex_fwd_valid = 0; ex_fwd_idx = 0; ex_fwd_data = 0; ex_fwd_is_load = 0;
    wb_fwd_valid = 0; wb_fwd_idx = 0; wb_fwd_data = 0; out_ready = 1;
  endtask

  task automatic applyStimulus(input logic [RW-1:0] rs, input logic [DW-1:0] rsv,
                               input logic [RW-1:0] rt, input logic [DW-1:0] rtv,
                               input logic [DW-1:0] imm, input logic uimm,
                               input logic [CW-1:0] c, input logic [RW-1:0] rd);
    in_valid = 1; in_rs_idx = rs; in_rs_val = rsv; in_rt_idx = rt; in_rt_val = rtv;
    in_imm = imm; in_use_imm = uimm; in_cmd = c; in_rd_idx = rd;
  endtask

  task automatic pushExp(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [CW-1:0] c, input logic [RW-1:0] rd);
    issue_t e;
    e.opa = a; e.opb = b; e.cmd = c; e.rd = rd;
    expQ.push_back(e);
  endtask

  // Scoreboard: every transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      xfers++;
      if (expQ.size() == 0) begin
        checkOutput("xfer_unexpected", 32'd1, 32'd0);
      end else begin
        issue_t e;
        e = expQ.pop_front();
        checkOutput("sb_opa", opa, e.opa);
        checkOutput("sb_opb", opb, e.opb);
        checkOutput("sb_cmd", {28'd0, cmd}, {28'd0, e.cmd});
        checkOutput("sb_rd", {27'd0, out_rd_idx}, {27'd0, e.rd});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int x0;
    idleInputs();
    rst_n = 0;
    tick(); tick();
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_opa", opa, 32'd0);
    checkOutput("rst_opb", opb, 32'd0);
    checkOutput("rst_cmd", {28'd0, cmd}, 32'd0);
    checkOutput("rst_rd", {27'd0, out_rd_idx}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1;
    tick();

    // No hazard, plain register-file operands
    applyStimulus(3, 10, 4, 20, 0, 0, 4'd0, 5'd1);
    pushExp(10, 20, 4'd0, 5'd1);
    #1 checkOutput("nohaz_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    idleInputs();
    checkOutput("nohaz_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("nohaz_opa", opa, 32'd10);
    tick();
    checkOutput("nohaz_drained", {31'd0, out_valid}, 32'd0);

    // EX forward beats WB forward for the same index
    applyStimulus(5, 1, 6, 2, 0, 0, 4'd1, 5'd2);
    ex_fwd_valid = 1; ex_fwd_idx = 5; ex_fwd_data = 32'h55;
    wb_fwd_valid = 1; wb_fwd_idx = 5; wb_fwd_data = 32'h77;
    pushExp(32'h55, 2, 4'd1, 5'd2);
    tick();
    idleInputs();
    checkOutput("exfwd_opa", opa, 32'h55);
    tick();

    // Load-use on rt: two stall cycles, then WB supplies the load data
    applyStimulus(8, 3, 7, 4, 0, 0, 4'd2, 5'd3);
    ex_fwd_valid = 1; ex_fwd_idx = 7; ex_fwd_is_load = 1;
    pushExp(3, 32'h99, 4'd2, 5'd3);
    tick();
    in_valid = 0;
    #1;
    checkOutput("lu_valid_c1", {31'd0, out_valid}, 32'd0);
    checkOutput("lu_ready_c1", {31'd0, in_ready}, 32'd0);
    tick();
    ex_fwd_valid = 0; ex_fwd_is_load = 0;
    wb_fwd_valid = 1; wb_fwd_idx = 7; wb_fwd_data = 32'h99;
    #1;
    checkOutput("lu_valid_c2", {31'd0, out_valid}, 32'd0);
    checkOutput("lu_ready_c2", {31'd0, in_ready}, 32'd0);
    tick();
    idleInputs();
    checkOutput("lu_valid_after", {31'd0, out_valid}, 32'd1);
    checkOutput("lu_opb", opb, 32'h99);
`ifdef ALU_ISSUE_STALL_CNT_EN
    checkOutput("lu_stall_cnt", stall_cnt, 32'd2);
`endif
    tick();

    // Load hazard on rt is ignored when opb takes the immediate
    applyStimulus(8, 3, 7, 4, 32'h1234, 1, 4'd3, 5'd4);
    ex_fwd_valid = 1; ex_fwd_idx = 7; ex_fwd_is_load = 1;
    pushExp(3, 32'h1234, 4'd3, 5'd4);
    tick();
    idleInputs();
    checkOutput("imm_no_stall", {31'd0, out_valid}, 32'd1);
    tick();

    // Back-to-back: two instructions on consecutive cycles
    applyStimulus(1, 32'hA1, 2, 32'hA2, 0, 0, 4'd4, 5'd5);
    pushExp(32'hA1, 32'hA2, 4'd4, 5'd5);
    tick();
    applyStimulus(2, 32'hB1, 1, 32'hB2, 0, 0, 4'd5, 5'd6);
    pushExp(32'hB1, 32'hB2, 4'd5, 5'd6);
    #1 checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    idleInputs();
    checkOutput("b2b_second_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("b2b_second_opa", opa, 32'hB1);
    tick();

    // Backpressure with WB retiring rs while held
    applyStimulus(9, 32'h11, 10, 32'h22, 0, 0, 4'd3, 5'd7);
    out_ready = 0;
    tick();
    in_valid = 0;
    #1;
    checkOutput("bp_opa_initial", opa, 32'h11);
    checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    wb_fwd_valid = 1; wb_fwd_idx = 9; wb_fwd_data = 32'hAB;
    tick();
    checkOutput("bp_opa_wb", opa, 32'hAB);
    checkOutput("bp_cmd_stable", {28'd0, cmd}, 32'd3);
    checkOutput("bp_valid_held", {31'd0, out_valid}, 32'd1);
    tick();
    wb_fwd_valid = 0;
    x0 = xfers;
    pushExp(32'hAB, 32'h22, 4'd3, 5'd7);
    out_ready = 1;
    tick();
    checkOutput("bp_one_xfer", x0 + 1, xfers);
    checkOutput("bp_drained", {31'd0, out_valid}, 32'd0);

    // Register zero ignores EX data and never raises a load hazard
    applyStimulus(0, 32'h123, 11, 5, 0, 0, 4'd6, 5'd8);
    ex_fwd_valid = 1; ex_fwd_idx = 0; ex_fwd_data = 32'hFFFF; ex_fwd_is_load = 1;
    pushExp(0, 5, 4'd6, 5'd8);
    tick();
    idleInputs();
    checkOutput("r0_no_stall", {31'd0, out_valid}, 32'd1);
    checkOutput("r0_opa", opa, 32'd0);
    tick();

    // Flush during STALL returns to EMPTY even once the hazard clears
    applyStimulus(12, 1, 13, 2, 0, 0, 4'd7, 5'd9);
    ex_fwd_valid = 1; ex_fwd_idx = 12; ex_fwd_is_load = 1;
    tick();
    in_valid = 0; flush = 1;
    #1 checkOutput("fl_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    idleInputs();
    checkOutput("fl_valid_next", {31'd0, out_valid}, 32'd0);
    tick();
    checkOutput("fl_stays_empty", {31'd0, out_valid}, 32'd0);

    // Flush dominates in_valid in EMPTY
    applyStimulus(1, 5, 2, 6, 0, 0, 4'd1, 5'd1);
    flush = 1;
    #1 checkOutput("fl_dom_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    idleInputs();
    checkOutput("fl_dom_no_capture", {31'd0, out_valid}, 32'd0);
    tick();

    // Asynchronous reset while FULL and backpressured
    applyStimulus(14, 32'h44, 15, 32'h66, 0, 0, 4'd9, 5'd10);
    out_ready = 0;
    tick();
    in_valid = 0;
    checkOutput("rf_full", {31'd0, out_valid}, 32'd1);
    rst_n = 0;
    #1;
    checkOutput("rf_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rf_opa", opa, 32'd0);
    checkOutput("rf_cmd", {28'd0, cmd}, 32'd0);
    checkOutput("rf_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    tick(); tick();
    checkOutput("rf_stays_empty", {31'd0, out_valid}, 32'd0);
    checkOutput("sb_queue_empty", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
